// File: rtl/taglist_pkg.sv
// Shared types and field-offset helpers for the tag-list generator.
// Offsets are functions of ADDR_W so every parametrisation shares one layout rule.
package taglist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LE_SEQ = 2'b10;
    localparam logic [1:0] LE_ROM = 2'b11;

    localparam int END_LSB  = 0;
    localparam int LAST_LSB = 1;

    function automatic int first_lsb(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int seq_lsb(input int addr_w);
        return 2 * addr_w + 1;
    endfunction

    function automatic int word_bits(input int addr_w, input int seq_w);
        return 2 * addr_w + seq_w + 1;
    endfunction

endpackage

// File: rtl/taglist_gen_p_word_pack.sv
// Combinational packing of one sequence descriptor into a RAM word.
// Unused upper bits are driven to zero.
module taglist_word_pack
    import taglist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SEQ_W  = 7,
    parameter int DATA_W = 32
) (
    input  logic [SEQ_W-1:0]  seq_num,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    input  logic              end_flag,
    output logic [DATA_W-1:0] word
);

    localparam int FIRST_LSB = first_lsb(ADDR_W);
    localparam int SEQ_LSB   = seq_lsb(ADDR_W);

    generate
        if (DATA_W < word_bits(ADDR_W, SEQ_W)) begin : g_width_check
            $error("taglist_word_pack: DATA_W too small for the descriptor fields");
        end
    endgenerate

    always_comb begin
        word                         = '0;
        word[END_LSB]                = end_flag;
        word[LAST_LSB +: ADDR_W]     = last;
        word[FIRST_LSB +: ADDR_W]    = first;
        word[SEQ_LSB +: SEQ_W]       = seq_num;
    end

endmodule

// File: rtl/taglist_gen_p.sv
// Tag-list generator: scans the tag ROM one address per clock and writes one
// descriptor per sequence into the tag-list RAM, with backpressure and overflow.
module taglist_gen_p
    import taglist_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int SEQ_W      = 7,
    parameter int DATA_W     = 32,
    parameter int START_ADDR = 0
) (
    input  logic              clk_1KHz,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        lastEnd,
    input  logic              ram_ready,
    output logic [ADDR_W-1:0] romAddr,
    output logic [DATA_W-1:0] ramData,
    output logic [SEQ_W-1:0]  ramAddr,
    output logic              w_e_RAM,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [SEQ_W:0]    seqCount
);

    localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [SEQ_W-1:0]  SEQ_MAX  = '1;

    state_t            state;
    logic [ADDR_W-1:0] first;
    logic              end_flag;
    logic              end_next;
    logic [DATA_W-1:0] packed_word;

    // ramAddr doubles as the running sequence number.
    assign end_next = lastEnd[1] ? lastEnd[0] : 1'b1;

    taglist_word_pack #(
        .ADDR_W (ADDR_W),
        .SEQ_W  (SEQ_W),
        .DATA_W (DATA_W)
    ) u_pack (
        .seq_num  (ramAddr),
        .first    (first),
        .last     (romAddr),
        .end_flag (end_next),
        .word     (packed_word)
    );

    always_ff @(posedge clk_1KHz or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            romAddr  <= '0;
            first    <= '0;
            end_flag <= 1'b0;
            ramData  <= '0;
            ramAddr  <= '0;
            w_e_RAM  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            seqCount <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        romAddr  <= START;
                        first    <= START;
                        ramAddr  <= '0;
                        seqCount <= '0;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (!lastEnd[1] && romAddr != ADDR_MAX) begin
                        romAddr <= romAddr + 1'b1;
                    end else begin
                        // The current address closes a sequence (or the ROM wrapped).
                        end_flag <= end_next;
                        ramData  <= packed_word;
                        w_e_RAM  <= 1'b1;
                        if (!lastEnd[1]) overflow <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (ram_ready) begin
                        w_e_RAM  <= 1'b0;
                        seqCount <= seqCount + 1'b1;
                        if (end_flag) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (ramAddr == SEQ_MAX) begin
                            overflow <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            ramAddr <= ramAddr + 1'b1;
                            romAddr <= romAddr + 1'b1;
                            first   <= romAddr + 1'b1;
                            state   <= SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_taglist_gen_p.sv
// Directed bench for taglist_gen_p: default build, a SEQ_W=2 build and an ADDR_W=3 build.
module tb_taglist_gen_p;

    logic clk;
    logic reset;

    // Instance A: default parameters
    logic        start_a, rdy_a;
    logic [1:0]  le_a;
    logic [9:0]  rom_a;
    logic [31:0] data_a;
    logic [6:0]  addr_a;
    logic        we_a, busy_a, done_a, ovf_a;
    logic [7:0]  cnt_a;
    int          mode_a;

    // Instance B: SEQ_W = 2
    logic        start_b;
    logic [1:0]  le_b;
    logic [9:0]  rom_b;
    logic [31:0] data_b;
    logic [1:0]  addr_b;
    logic        we_b, busy_b, done_b, ovf_b;
    logic [2:0]  cnt_b;

    // Instance C: ADDR_W = 3
    logic        start_c;
    logic [1:0]  le_c;
    logic [2:0]  rom_c;
    logic [31:0] data_c;
    logic [6:0]  addr_c;
    logic        we_c, busy_c, done_c, ovf_c;
    logic [7:0]  cnt_c;

    logic [31:0] qa_data[$];
    int          qa_addr[$];
    logic [31:0] qb_data[$];
    int          qb_addr[$];
    logic [31:0] qc_data[$];
    int          qc_addr[$];

    int n_total;
    int n_bad;

    taglist_gen_p u_dut_a (
        .clk_1KHz (clk), .reset (reset), .start (start_a), .lastEnd (le_a),
        .ram_ready (rdy_a), .romAddr (rom_a), .ramData (data_a), .ramAddr (addr_a),
        .w_e_RAM (we_a), .busy (busy_a), .done (done_a), .overflow (ovf_a),
        .seqCount (cnt_a)
    );

    taglist_gen_p #(.SEQ_W(2)) u_dut_b (
        .clk_1KHz (clk), .reset (reset), .start (start_b), .lastEnd (le_b),
        .ram_ready (1'b1), .romAddr (rom_b), .ramData (data_b), .ramAddr (addr_b),
        .w_e_RAM (we_b), .busy (busy_b), .done (done_b), .overflow (ovf_b),
        .seqCount (cnt_b)
    );

    taglist_gen_p #(.ADDR_W(3)) u_dut_c (
        .clk_1KHz (clk), .reset (reset), .start (start_c), .lastEnd (le_c),
        .ram_ready (1'b1), .romAddr (rom_c), .ramData (data_c), .ramAddr (addr_c),
        .w_e_RAM (we_c), .busy (busy_c), .done (done_c), .overflow (ovf_c),
        .seqCount (cnt_c)
    );

    // ROM models
    assign le_a = (mode_a == 1) ? 2'b11 :
                  (rom_a == 10'd3) ? 2'b10 :
                  (rom_a == 10'd5) ? 2'b11 : 2'b00;
    assign le_b = 2'b10;
    assign le_c = 2'b00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A write request seen at the falling edge with ready high completes at the next rising edge.
    always @(negedge clk) begin
        if (we_a && rdy_a) begin
            qa_data.push_back(data_a);
            qa_addr.push_back(int'(addr_a));
        end
        if (we_b) begin
            qb_data.push_back(data_b);
            qb_addr.push_back(int'(addr_b));
        end
        if (we_c) begin
            qc_data.push_back(data_c);
            qc_addr.push_back(int'(addr_c));
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int which);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_done(input int which, output int n);
        logic d;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
            if (d) return;
        end
        n = -1;
    endtask

    task automatic run_s1(input string pfx);
        int n;
        qa_data.delete();
        qa_addr.delete();
        mode_a = 0;
        rdy_a  = 1'b1;
        pulse_start(0);
        check({pfx, "_busy"}, busy_a, 1);
        check({pfx, "_rom0"}, rom_a, 0);
        wait_done(0, n);
        check({pfx, "_cycles"}, n, 8);
        check({pfx, "_nwr"}, qa_data.size(), 2);
        if (qa_data.size() >= 2) begin
            check({pfx, "_addr0"}, qa_addr[0], 0);
            check({pfx, "_data0"}, qa_data[0], 32'h0000_0006);
            check({pfx, "_addr1"}, qa_addr[1], 1);
            check({pfx, "_data1"}, qa_data[1], 32'h0020_200B);
        end
        check({pfx, "_cnt"}, cnt_a, 2);
        check({pfx, "_ovf"}, ovf_a, 0);
        check({pfx, "_busy_end"}, busy_a, 0);
        check({pfx, "_we_end"}, we_a, 0);
    endtask

    initial begin
        int n;
        int m;
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        rdy_a   = 1'b1;
        mode_a  = 0;
        tick();
        tick();
        check("rst_rom", rom_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_we", we_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_data", data_a, 0);
        reset = 1'b0;
        tick();

        // Two sequences, no stall
        run_s1("s1");

        // Single-address ROM
        qa_data.delete();
        qa_addr.delete();
        mode_a = 1;
        pulse_start(0);
        wait_done(0, n);
        check("s2_cycles", n, 2);
        check("s2_nwr", qa_data.size(), 1);
        if (qa_data.size() >= 1) check("s2_data", qa_data[0], 32'h0000_0001);
        check("s2_cnt", cnt_a, 1);

        // Backpressure on entry 0
        qa_data.delete();
        qa_addr.delete();
        mode_a = 0;
        rdy_a  = 1'b0;
        pulse_start(0);
        repeat (4) tick();
        n = 4;
        for (int i = 0; i < 4; i++) begin
            check("s3_we_hold", we_a, 1);
            check("s3_data_hold", data_a, 32'h0000_0006);
            if (i < 3) begin
                tick();
                n++;
            end
        end
        rdy_a = 1'b1;
        wait_done(0, m);
        check("s3_cycles", (m < 0) ? -1 : n + m, 11);
        check("s3_nwr", qa_data.size(), 2);
        if (qa_data.size() >= 1) check("s3_data0", qa_data[0], 32'h0000_0006);
        check("s3_cnt", cnt_a, 2);

        // Asynchronous reset mid-scan
        pulse_start(0);
        tick();
        tick();
        check("s6_pre_rom", rom_a, 2);
        #3 reset = 1'b1;
        #1;
        check("s6_rst_rom", rom_a, 0);
        check("s6_rst_busy", busy_a, 0);
        check("s6_rst_done", done_a, 0);
        check("s6_rst_cnt", cnt_a, 0);
        check("s6_rst_ovf", ovf_a, 0);
        check("s6_rst_addr", addr_a, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("s6_idle_rom", rom_a, 0);
        check("s6_idle_busy", busy_a, 0);

        // Start while busy is ignored
        qa_data.delete();
        qa_addr.delete();
        pulse_start(0);
        tick();
        tick();
        pulse_start(0);
        check("s6_ign_rom", rom_a, 3);
        check("s6_ign_busy", busy_a, 1);
        wait_done(0, n);
        check("s6_ign_nwr", qa_data.size(), 2);
        check("s6_done", done_a, 1);

        // Restart from DONE reruns the two-sequence scan
        run_s1("s6r");

        // Entry limit with SEQ_W = 2
        pulse_start(1);
        wait_done(1, n);
        check("s4_cycles", n, 8);
        check("s4_nwr", qb_data.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (qb_data.size() > k) begin
                check("s4_addr", qb_addr[k], k);
                check("s4_data", qb_data[k], (k << 21) | (k << 11) | (k << 1));
            end
        end
        check("s4_ovf", ovf_b, 1);
        check("s4_done", done_b, 1);
        check("s4_cnt", cnt_b, 4);
        check("s4_rom", rom_b, 3);

        // Address wrap with ADDR_W = 3
        pulse_start(2);
        wait_done(2, n);
        check("s5_cycles", n, 9);
        check("s5_nwr", qc_data.size(), 1);
        if (qc_data.size() >= 1) begin
            check("s5_data", qc_data[0], 32'h0000_000F);
            check("s5_addr", qc_addr[0], 0);
        end
        check("s5_ovf", ovf_c, 1);
        check("s5_cnt", cnt_c, 1);
        check("s5_rom", rom_c, 7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
